// File: rtl/timer_ctrl.sv
// Run/pause/set controller for an mm:ss BCD timer with 1 Hz prescaler.
// Optional digit blinking in the set modes is compiled in with `define BLINK_EN.
module timer_ctrl #(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_clr,
    output logic [3:0] sec_l,
    output logic [3:0] sec_h,
    output logic [3:0] min_l,
    output logic [3:0] min_h,
    output logic [2:0] state_o,
    output logic       tick_o,
    output logic       wrap_o,
    output logic [3:0] blank_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSE   = 3'd2,
        SET_MIN = 3'd3,
        SET_SEC = 3'd4
    } state_t;

    localparam int unsigned     PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      sec_d, min_d;
    logic [8:0]      sec_inc, min_inc;
    logic            tick_d, wrap_d;
    logic            inc_hit;

    // Two-digit BCD increment modulo 60; returns {carry_out, tens, units}.
    function automatic logic [8:0] bcd60_inc(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        logic       cy;
        hi = v[7:4];
        lo = v[3:0];
        cy = 1'b0;
        if (lo >= 4'd9) begin
            lo = 4'd0;
            if (hi >= 4'd5) begin
                hi = 4'd0;
                cy = 1'b1;
            end else begin
                hi = hi + 4'd1;
            end
        end else begin
            lo = lo + 4'd1;
        end
        return {cy, hi, lo};
    endfunction

    assign sec_inc = bcd60_inc({sec_h, sec_l});
    assign min_inc = bcd60_inc({min_h, min_l});
    assign state_o = state_q;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = {sec_h, sec_l};
        min_d   = {min_h, min_l};
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        inc_hit = 1'b0;
        if (btn_clr) begin
            state_d = IDLE;
            presc_d = '0;
            sec_d   = 8'h00;
            min_d   = 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (btn_start)     state_d = RUN;
                    else if (btn_mode) state_d = SET_MIN;
                end
                RUN: begin
                    // A tick coinciding with start still lands; the prescaler restarts from 0.
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        sec_d   = sec_inc[7:0];
                        if (sec_inc[8]) begin
                            min_d  = min_inc[7:0];
                            wrap_d = min_inc[8];
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                    if (btn_start) state_d = PAUSE;
                end
                PAUSE: begin
                    if (btn_start)     state_d = RUN;
                    else if (btn_mode) state_d = SET_MIN;
                end
                SET_MIN: begin
                    presc_d = '0;
                    if (btn_start)     state_d = RUN;
                    else if (btn_mode) state_d = SET_SEC;
                    else if (btn_inc) begin
                        min_d   = min_inc[7:0];
                        inc_hit = 1'b1;
                    end
                end
                SET_SEC: begin
                    presc_d = '0;
                    if (btn_start)     state_d = RUN;
                    else if (btn_mode) state_d = PAUSE;
                    else if (btn_inc) begin
                        sec_d   = sec_inc[7:0];
                        inc_hit = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            presc_q        <= '0;
            {sec_h, sec_l} <= 8'h00;
            {min_h, min_l} <= 8'h00;
            tick_o         <= 1'b0;
            wrap_o         <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            {sec_h, sec_l} <= sec_d;
            {min_h, min_l} <= min_d;
            tick_o         <= tick_d;
            wrap_o         <= wrap_d;
        end
    end

`ifdef BLINK_EN
    localparam int unsigned   BW         = $clog2(2 * BLINK_DIV);
    localparam logic [BW-1:0] BLINK_MAX  = BW'(2 * BLINK_DIV - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_DIV);

    logic [BW-1:0] blink_q, blink_d;
    logic [3:0]    blank_d;

    // Blank pattern is derived from next-cycle values so it lines up with the registered state.
    always_comb begin
        blink_d = (blink_q == BLINK_MAX) ? '0 : blink_q + 1'b1;
        if ((state_d == SET_MIN || state_d == SET_SEC) && (state_d != state_q || inc_hit))
            blink_d = '0;
        blank_d = 4'b0000;
        if (blink_d >= BLINK_HALF) begin
            if (state_d == SET_MIN)      blank_d = 4'b1100;
            else if (state_d == SET_SEC) blank_d = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_q <= '0;
            blank_o <= 4'b0000;
        end else begin
            blink_q <= blink_d;
            blank_o <= blank_d;
        end
    end
`else
    // Keeps BLINK_DIV and the increment strobe referenced when blinking is compiled out.
    logic unused_blink;
    assign unused_blink = ^{inc_hit, BLINK_DIV};
    assign blank_o      = 4'b0000;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl with TICK_DIV=4, BLINK_DIV=3.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_start, btn_mode, btn_inc, btn_clr;
    logic [3:0] sec_l, sec_h, min_l, min_h;
    logic [2:0] state_o;
    logic       tick_o, wrap_o;
    logic [3:0] blank_o;
    logic [15:0] digits;

    int passed = 0;
    int total  = 0;
    bit any_wrap;

    timer_ctrl #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_start(btn_start), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_clr(btn_clr),
        .sec_l(sec_l), .sec_h(sec_h), .min_l(min_l), .min_h(min_h),
        .state_o(state_o), .tick_o(tick_o), .wrap_o(wrap_o), .blank_o(blank_o)
    );

    always #5 clk = ~clk;
    assign digits = {min_h, min_l, sec_h, sec_l};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic m, input logic i, input logic c);
        btn_start = s; btn_mode = m; btn_inc = i; btn_clr = c;
        @(posedge clk);
        #1;
        btn_start = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        btn_start = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_clr = 1'b0;
        step(3);
        check("rst_state", 16'(state_o), 16'd0);
        check("rst_digits", digits, 16'h0000);
        check("rst_tick", 16'(tick_o), 16'd0);
        check("rst_wrap", 16'(wrap_o), 16'd0);
        check("rst_blank", 16'(blank_o), 16'h0);
        rst_n = 1'b1;
        step(1);

        // IDLE ignores inc
        press(0, 0, 1, 0);
        check("idle_inc_state", 16'(state_o), 16'd0);
        check("idle_inc_digits", digits, 16'h0000);

        // Run: first tick exactly 4 cycles after the start edge
        press(1, 0, 0, 0);
        check("run_state", 16'(state_o), 16'd1);
        step(3);
        check("run_notick_c3", 16'(tick_o), 16'd0);
        step(1);
        check("run_tick_c4", 16'(tick_o), 16'd1);
        check("run_digits_c4", digits, 16'h0001);
        step(36);
        check("run_digits_c40", digits, 16'h0010);

        // Preload 59:58 via set modes, then roll over
        press(0, 0, 0, 1);
        check("clr_state", 16'(state_o), 16'd0);
        check("clr_digits", digits, 16'h0000);
        press(0, 1, 0, 0);
        check("set_min_state", 16'(state_o), 16'd3);
        for (int k = 0; k < 59; k++) press(0, 0, 1, 0);
        check("set_min59", digits, 16'h5900);
        press(0, 1, 0, 0);
        check("set_sec_state", 16'(state_o), 16'd4);
        for (int k = 0; k < 58; k++) press(0, 0, 1, 0);
        check("set_5958", digits, 16'h5958);
        press(1, 0, 0, 0);
        step(4);
        check("wrap_t1_digits", digits, 16'h5959);
        check("wrap_t1_wrap", 16'(wrap_o), 16'd0);
        step(4);
        check("wrap_t2_digits", digits, 16'h0000);
        check("wrap_t2_tick", 16'(tick_o), 16'd1);
        check("wrap_t2_wrap", 16'(wrap_o), 16'd1);
        step(1);
        check("wrap_after", 16'(wrap_o), 16'd0);

        // Pause after two prescaler counts, resume finishes the remaining two
        press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        step(1);
        press(1, 0, 0, 0);
        check("pause_state", 16'(state_o), 16'd2);
        step(20);
        check("pause_hold_digits", digits, 16'h0000);
        check("pause_hold_state", 16'(state_o), 16'd2);
        press(1, 0, 0, 0);
        check("resume_state", 16'(state_o), 16'd1);
        step(1);
        check("resume_notick", 16'(tick_o), 16'd0);
        step(1);
        check("resume_tick", 16'(tick_o), 16'd1);
        check("resume_digits", digits, 16'h0001);

        // Set-mode wraps: minutes 00->59->00->01 without wrap_o
        press(0, 0, 0, 1);
        press(0, 1, 0, 0);
        any_wrap = 1'b0;
        for (int k = 0; k < 60; k++) begin
            press(0, 0, 1, 0);
            any_wrap |= wrap_o;
        end
        check("set_min60", digits, 16'h0000);
        press(0, 0, 1, 0);
        any_wrap |= wrap_o;
        check("set_min61", digits, 16'h0100);
        check("set_no_wrap", 16'(any_wrap), 16'd0);
        press(0, 1, 0, 0);
        for (int k = 0; k < 9; k++) press(0, 0, 1, 0);
        check("set_sec09", digits, 16'h0109);
        press(0, 1, 1, 0);
        check("mode_over_inc_state", 16'(state_o), 16'd2);
        check("mode_over_inc_digits", digits, 16'h0109);

        // clr beats start while running at 03:27
        press(0, 0, 0, 1);
        press(0, 1, 0, 0);
        for (int k = 0; k < 3; k++) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        for (int k = 0; k < 27; k++) press(0, 0, 1, 0);
        check("preload_0327", digits, 16'h0327);
        press(1, 0, 0, 0);
        step(1);
        press(1, 0, 0, 1);
        check("clr_start_state", 16'(state_o), 16'd0);
        check("clr_start_digits", digits, 16'h0000);
        press(1, 0, 0, 0);
        step(3);
        check("clr_presc_notick", 16'(tick_o), 16'd0);
        step(1);
        check("clr_presc_tick", 16'(tick_o), 16'd1);
        check("clr_presc_digits", digits, 16'h0001);

        // Tick and start in the same cycle
        step(3);
        press(1, 0, 0, 0);
        check("tick_start_tick", 16'(tick_o), 16'd1);
        check("tick_start_digits", digits, 16'h0002);
        check("tick_start_state", 16'(state_o), 16'd2);
        press(1, 0, 0, 0);
        step(3);
        check("tick_start_presc0", 16'(tick_o), 16'd0);
        step(1);
        check("tick_start_next", digits, 16'h0003);

        // Reset landing on a tick edge
        step(3);
        rst_n = 1'b0;
        step(1);
        check("midrst_state", 16'(state_o), 16'd0);
        check("midrst_digits", digits, 16'h0000);
        check("midrst_tick", 16'(tick_o), 16'd0);
        check("midrst_wrap", 16'(wrap_o), 16'd0);
        rst_n = 1'b1;
        step(1);

`ifdef BLINK_EN
        press(0, 1, 0, 0);
        check("blink_min_c0", 16'(blank_o), 16'h0);
        step(2);
        check("blink_min_c2", 16'(blank_o), 16'h0);
        step(1);
        check("blink_min_c3", 16'(blank_o), 16'hC);
        step(2);
        check("blink_min_c5", 16'(blank_o), 16'hC);
        step(1);
        check("blink_min_c6", 16'(blank_o), 16'h0);
        press(0, 1, 0, 0);
        check("blink_sec_c0", 16'(blank_o), 16'h0);
        step(3);
        check("blink_sec_c3", 16'(blank_o), 16'h3);
        press(0, 0, 1, 0);
        check("blink_inc_restart", 16'(blank_o), 16'h0);
        press(1, 0, 0, 0);
        step(3);
        check("blink_run", 16'(blank_o), 16'h0);
`else
        press(0, 1, 0, 0);
        step(4);
        check("noblink_min", 16'(blank_o), 16'h0);
        press(0, 1, 0, 0);
        step(4);
        check("noblink_sec", 16'(blank_o), 16'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
